// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller behind the UART receiver: turns 4-byte frames
// (sync, addr, data, checksum) into register writes, dropping and counting bad frames.
module uart_cmd_ctrl #(
  parameter int          CLK_PER_BIT   = 87,
  parameter int          TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err,
  output logic [7:0] o_err_count,
  output logic       o_busy
);

  typedef enum logic [1:0] {S_SYNC, S_ADDR, S_DATA, S_CHK} state_t;

  localparam logic [23:0] TIMEOUT_LIMIT = 24'(TIMEOUT_BYTES * 10 * CLK_PER_BIT - 1);

  state_t      state, next_state;
  logic        r_done_d;
  logic [7:0]  acc, acc_nxt;
  logic [7:0]  addr, addr_nxt;
  logic [7:0]  data, data_nxt;
  logic [23:0] tmo_cnt;
  logic        strobe, tmo_hit, commit, frame_err_nxt;
  logic [7:0]  sum;

  // The receiver's done flag is a level; a completed byte is its rising edge.
  assign strobe  = i_rx_done & ~r_done_d;
  assign tmo_hit = (tmo_cnt == TIMEOUT_LIMIT);
  assign sum     = acc + i_rx_data;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    next_state    = state;
    acc_nxt       = acc;
    addr_nxt      = addr;
    data_nxt      = data;
    commit        = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (state)
      S_SYNC: begin
        if (strobe && i_rx_data == SYNC_BYTE) begin
          next_state = S_ADDR;
          acc_nxt    = SYNC_BYTE;
        end
      end
      S_ADDR: begin
        if (strobe) begin
          addr_nxt   = i_rx_data;
          acc_nxt    = sum;
          next_state = S_DATA;
        end else if (tmo_hit) begin
          frame_err_nxt = 1'b1;
          next_state    = S_SYNC;
        end
      end
      S_DATA: begin
        if (strobe) begin
          data_nxt   = i_rx_data;
          acc_nxt    = sum;
          next_state = S_CHK;
        end else if (tmo_hit) begin
          frame_err_nxt = 1'b1;
          next_state    = S_SYNC;
        end
      end
      S_CHK: begin
        // A strobe on the timeout cycle takes priority over the timeout.
        if (strobe) begin
          commit        = (sum == 8'h00);
          frame_err_nxt = (sum != 8'h00);
          next_state    = S_SYNC;
        end else if (tmo_hit) begin
          frame_err_nxt = 1'b1;
          next_state    = S_SYNC;
        end
      end
      default: next_state = S_SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= S_SYNC;
      r_done_d    <= 1'b1;
      acc         <= 8'h00;
      addr        <= 8'h00;
      data        <= 8'h00;
      tmo_cnt     <= 24'd0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= 8'h00;
      o_wr_data   <= 8'h00;
      o_frame_err <= 1'b0;
      o_err_count <= 8'h00;
      o_busy      <= 1'b0;
    end else begin
      state       <= next_state;
      r_done_d    <= i_rx_done;
      acc         <= acc_nxt;
      addr        <= addr_nxt;
      data        <= data_nxt;
      tmo_cnt     <= (state == S_SYNC || strobe) ? 24'd0 : tmo_cnt + 24'd1;
      o_wr_en     <= commit;
      o_frame_err <= frame_err_nxt;
      o_busy      <= (next_state != S_SYNC);
      if (commit) begin
        o_wr_addr <= addr;
        o_wr_data <= data;
      end
      if (frame_err_nxt && o_err_count != 8'hFF)
        o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: table-driven frames plus hand-written
// timeout, reset, saturation and back-to-back sequences.
module tb_uart_cmd_ctrl;

  localparam int CLK_PER_BIT   = 87;
  localparam int TIMEOUT_BYTES = 4;
  localparam int TMO_CYCLES    = TIMEOUT_BYTES * 10 * CLK_PER_BIT;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_err;
  logic [7:0] o_err_count;
  logic       o_busy;

  uart_cmd_ctrl #(
    .CLK_PER_BIT  (CLK_PER_BIT),
    .TIMEOUT_BYTES(TIMEOUT_BYTES),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_frame_err(o_frame_err),
    .o_err_count(o_err_count),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse monitor, sampled on the rising edge (pre-update values).
  int wr_pulses = 0, wr_high = 0, err_pulses = 0, err_high = 0;
  logic prev_wr = 1'b0, prev_err = 1'b0;
  always @(posedge clk) begin
    if (o_wr_en) wr_high++;
    if (o_wr_en && !prev_wr) wr_pulses++;
    if (o_frame_err) err_high++;
    if (o_frame_err && !prev_err) err_pulses++;
    prev_wr  = o_wr_en;
    prev_err = o_frame_err;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Returns on the falling edge right after the strobe has been clocked in.
  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b0;
    i_rx_data = b;
    @(negedge clk);
    i_rx_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_byte(f[31:24]);
    send_byte(f[23:16]);
    send_byte(f[15:8]);
    send_byte(f[7:0]);
  endtask

  typedef struct {
    string       name;
    logic [31:0] frame;
    logic        exp_wr;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] last_addr = 8'h00, last_data = 8'h00;
  int exp_err_cnt = 0;

  task automatic bump_err();
    if (exp_err_cnt < 255) exp_err_cnt++;
  endtask

  initial begin
    vecs[0] = '{"valid",     32'hA5103C0F, 1'b1, 8'h10, 8'h3C};
    vecs[1] = '{"bad_chk",   32'hA5103C10, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{"valid2",    32'hA5010258, 1'b1, 8'h01, 8'h02};
    vecs[3] = '{"sync_addr", 32'hA5A500B6, 1'b1, 8'hA5, 8'h00};
    vecs[4] = '{"wrap",      32'hA5FFFF5D, 1'b1, 8'hFF, 8'hFF};
    vecs[5] = '{"bad_chk2",  32'hA5203000, 1'b0, 8'h00, 8'h00};

    i_rst     = 1'b1;
    i_rx_done = 1'b1;
    i_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_wr_en",   32'(o_wr_en),     0);
    check("rst_addr",    32'(o_wr_addr),   0);
    check("rst_data",    32'(o_wr_data),   0);
    check("rst_err",     32'(o_frame_err), 0);
    check("rst_err_cnt", 32'(o_err_count), 0);
    check("rst_busy",    32'(o_busy),      0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].frame[31:24]);
      check({vecs[i].name, "_busy_mid"}, 32'(o_busy), 1);
      send_byte(vecs[i].frame[23:16]);
      send_byte(vecs[i].frame[15:8]);
      send_byte(vecs[i].frame[7:0]);
      if (vecs[i].exp_wr) begin
        last_addr = vecs[i].exp_addr;
        last_data = vecs[i].exp_data;
      end else begin
        bump_err();
      end
      check({vecs[i].name, "_wr_en"},   32'(o_wr_en),     32'(vecs[i].exp_wr));
      check({vecs[i].name, "_ferr"},    32'(o_frame_err), 32'(!vecs[i].exp_wr));
      check({vecs[i].name, "_busy"},    32'(o_busy),      0);
      check({vecs[i].name, "_addr"},    32'(o_wr_addr),   32'(last_addr));
      check({vecs[i].name, "_data"},    32'(o_wr_data),   32'(last_data));
      check({vecs[i].name, "_err_cnt"}, 32'(o_err_count), 32'(exp_err_cnt));
      @(negedge clk);
      check({vecs[i].name, "_pulse_end"}, 32'({o_wr_en, o_frame_err}), 0);
    end

    // Noise before sync is ignored silently.
    begin
      int w0, e0;
      w0 = wr_pulses; e0 = err_pulses;
      send_byte(8'h00);
      send_byte(8'hFF);
      check("noise_busy", 32'(o_busy), 0);
      send_frame(32'hA5010258);
      @(negedge clk);
      check("noise_writes", 32'(wr_pulses - w0), 1);
      check("noise_errs",   32'(err_pulses - e0), 0);
      check("noise_addr",   32'(o_wr_addr), 32'h01);
      check("noise_data",   32'(o_wr_data), 32'h02);
    end

    // Timeout: error exactly TMO_CYCLES after the address strobe.
    begin
      int k;
      send_byte(8'hA5);
      send_byte(8'h20);
      k = 0;
      while (!o_frame_err && k < TMO_CYCLES + 20) begin
        @(negedge clk);
        k++;
      end
      bump_err();
      check("tmo_latency", 32'(k), 32'(TMO_CYCLES));
      check("tmo_busy",    32'(o_busy), 0);
      check("tmo_err_cnt", 32'(o_err_count), 32'(exp_err_cnt));
    end

    // Strobe on the exact timeout cycle wins; frame then completes normally.
    send_byte(8'hA5);
    i_rx_done = 1'b0;
    i_rx_data = 8'h20;
    repeat (TMO_CYCLES - 1) @(negedge clk);
    i_rx_done = 1'b1;
    @(negedge clk);
    check("tie_no_err", 32'(o_frame_err), 0);
    check("tie_busy",   32'(o_busy), 1);
    send_byte(8'h30);
    send_byte(8'h0B);
    check("tie_wr_en",   32'(o_wr_en), 1);
    check("tie_addr",    32'(o_wr_addr), 32'h20);
    check("tie_data",    32'(o_wr_data), 32'h30);
    check("tie_err_cnt", 32'(o_err_count), 32'(exp_err_cnt));
    @(negedge clk);

    // Reset mid-frame clears everything and the next frame works.
    send_byte(8'hA5);
    send_byte(8'h40);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    exp_err_cnt = 0;
    check("mrst_outs", 32'({o_wr_en, o_frame_err, o_busy, o_wr_addr, o_wr_data}), 0);
    check("mrst_err_cnt", 32'(o_err_count), 0);
    @(negedge clk);
    check("mrst_no_strobe_busy", 32'(o_busy), 0);
    send_frame(32'hA5010159);
    check("mrst_wr_en", 32'(o_wr_en), 1);
    check("mrst_addr",  32'(o_wr_addr), 32'h01);
    check("mrst_data",  32'(o_wr_data), 32'h01);
    @(negedge clk);

    // Saturation after 260 bad frames.
    begin
      int e0;
      e0 = err_pulses;
      for (int i = 0; i < 260; i++) begin
        send_frame(32'hA5103C10);
        bump_err();
      end
      @(negedge clk);
      check("sat_pulses",  32'(err_pulses - e0), 260);
      check("sat_err_cnt", 32'(o_err_count), 32'(exp_err_cnt));
      check("sat_ff",      32'(o_err_count), 32'hFF);
    end

    // Back-to-back valid frames with no gap between them.
    begin
      int w0, h0;
      w0 = wr_pulses; h0 = wr_high;
      send_frame(32'hA5103C0F);
      check("b2b_first_wr", 32'(o_wr_en), 1);
      send_frame(32'hA5010258);
      check("b2b_second_wr", 32'(o_wr_en), 1);
      @(negedge clk);
      @(negedge clk);
      check("b2b_pulses", 32'(wr_pulses - w0), 2);
      check("b2b_width",  32'(wr_high - h0), 2);
      check("b2b_addr",   32'(o_wr_addr), 32'h01);
      check("b2b_data",   32'(o_wr_data), 32'h02);
      check("b2b_err_cnt", 32'(o_err_count), 32'hFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
